// File: rtl/popacc_pkg.sv
// rtl/popacc_pkg.sv - shared sizing/clamping/conversion helpers; POPACC_SAT_EN selects saturation over wrap
package popacc_pkg;

    // Conversion result: flag plus a wide signed value; callers keep the low bits they need.
    typedef struct packed {
        logic               ovf;
        logic signed [63:0] val;
    } conv_t;

    // Accumulator width that can hold a full frame at the largest shift without overflow.
    function automatic int acc_w(input int bw_in, input int max_shift, input int max_cyc);
        return bw_in + max_shift * (max_cyc - 1) + $clog2(max_cyc) + 1;
    endfunction

    // A zero-length frame behaves as a single beat; over-long frames are capped.
    function automatic int clamp_len(input int len, input int max_cyc);
        if (len < 1) return 1;
        if (len > max_cyc) return max_cyc;
        return len;
    endfunction

    function automatic int clamp_shift(input int s, input int max_shift);
        if (s > max_shift) return max_shift;
        return s;
    endfunction

    // Reduce a wide signed result to bw_out bits, either clipping or wrapping.
    function automatic conv_t sat_trunc(input logic signed [63:0] r, input int bw_out);
        conv_t              c;
`ifdef POPACC_SAT_EN
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi    = (64'sd1 <<< (bw_out - 1)) - 64'sd1;
        lo    = -(64'sd1 <<< (bw_out - 1));
        c.ovf = 1'b0;
        c.val = r;
        if (r > hi) begin
            c.ovf = 1'b1;
            c.val = hi;
        end else if (r < lo) begin
            c.ovf = 1'b1;
            c.val = lo;
        end
`else
        c.ovf = 1'b0;
        c.val = (r <<< (64 - bw_out)) >>> (64 - bw_out);
`endif
        return c;
    endfunction

endpackage

// File: rtl/popacc_lane.sv
// rtl/popacc_lane.sv - one channel: decaying shift-add accumulator and result register (POPACC_SAT_EN via sat_trunc)
module popacc_lane
    import popacc_pkg::*;
#(
    parameter int BW_IN  = 12,
    parameter int BW_OUT = 16,
    parameter int ACC_W  = 30,
    parameter int SH_W   = 2,
    parameter int LS_W   = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [BW_IN-1:0]  din,
    input  logic              acc_en,
    input  logic              first,
    input  logic [SH_W-1:0]   shift,
    input  logic [LS_W-1:0]   ls,
    input  logic              load,
    output logic [BW_OUT-1:0] dout,
    output logic              ovf
);

    logic signed [ACC_W-1:0] acc_q;
    logic signed [ACC_W-1:0] ext;
    logic signed [ACC_W-1:0] sum;
    logic signed [ACC_W-1:0] res;
    conv_t                   conv;
    logic                    unused_hi;

    // New beat is pre-scaled by LS; the running sum decays by the per-beat shift.
    always_comb begin
        ext  = {{(ACC_W-BW_IN){din[BW_IN-1]}}, din};
        sum  = first ? (ext <<< ls) : ((acc_q >>> shift) + (ext <<< ls));
        res  = sum >>> ls;
        conv = sat_trunc({{(64-ACC_W){res[ACC_W-1]}}, res}, BW_OUT);
    end

    assign unused_hi = ^conv.val[63:BW_OUT];

    // Running sum; a first beat overwrites it, so clr needs no action here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else if (acc_en) begin
            acc_q <= sum;
        end
    end

    // Result register, held until the next final beat loads it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout <= '0;
            ovf  <= 1'b0;
        end else if (load) begin
            dout <= conv.val[BW_OUT-1:0];
            ovf  <= conv.ovf;
        end
    end

endmodule

// File: rtl/popcount_shift_accumulator.sv
// rtl/popcount_shift_accumulator.sv - frame control and handshake around NO_CH lanes; POPACC_SAT_EN enables saturation
module popcount_shift_accumulator
    import popacc_pkg::*;
#(
    parameter int NO_CH     = 64,
    parameter int BW_IN     = 12,
    parameter int BW_OUT    = 16,
    parameter int MAX_CYC   = 8,
    parameter int MAX_SHIFT = 2
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               clr,
    input  logic [$clog2(MAX_CYC+1)-1:0]       cfg_len,
    input  logic [$clog2(MAX_SHIFT+1)-1:0]     cfg_shift,
    input  logic                               in_vld,
    output logic                               in_rdy,
    input  logic [NO_CH-1:0][BW_IN-1:0]        data_in,
    output logic                               out_vld,
    input  logic                               out_rdy,
    output logic [NO_CH-1:0][BW_OUT-1:0]       data_out,
    output logic [NO_CH-1:0]                   ovf,
    output logic                               busy
);

    localparam int LEN_W  = $clog2(MAX_CYC + 1);
    localparam int SH_W   = $clog2(MAX_SHIFT + 1);
    localparam int MAX_LS = MAX_SHIFT * (MAX_CYC - 1);
    localparam int LS_W   = (MAX_LS > 0) ? $clog2(MAX_LS + 1) : 1;
    localparam int ACC_W  = acc_w(BW_IN, MAX_SHIFT, MAX_CYC);

    logic [LEN_W-1:0] cnt;
    logic [LEN_W-1:0] len_q;
    logic [SH_W-1:0]  shift_q;
    logic             out_vld_q;

    logic             first;
    logic [LEN_W-1:0] eff_len;
    logic [SH_W-1:0]  eff_shift;
    logic [LS_W-1:0]  ls;
    logic             final_beat;
    logic             rdy_c;
    logic             accept;
    logic             load;

    // The first beat of a frame uses live config; later beats use the latched copy.
    always_comb begin
        first      = (cnt == '0);
        eff_len    = first ? LEN_W'(clamp_len(int'(cfg_len), MAX_CYC)) : len_q;
        eff_shift  = first ? SH_W'(clamp_shift(int'(cfg_shift), MAX_SHIFT)) : shift_q;
        ls         = LS_W'(int'(eff_shift) * (int'(eff_len) - 1));
        final_beat = (cnt == eff_len - LEN_W'(1));
        rdy_c      = !clr && !(final_beat && out_vld_q && !out_rdy);
        accept     = in_vld && rdy_c;
        load       = accept && final_beat;
    end

    // Beat counter and per-frame config latch; clr abandons the partial frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            len_q   <= LEN_W'(1);
            shift_q <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (accept) begin
            if (first) begin
                len_q   <= eff_len;
                shift_q <= eff_shift;
            end
            cnt <= final_beat ? '0 : cnt + LEN_W'(1);
        end
    end

    // Output valid: set on load, cleared on drain; load wins when both happen.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_vld_q <= 1'b0;
        end else if (load) begin
            out_vld_q <= 1'b1;
        end else if (out_rdy) begin
            out_vld_q <= 1'b0;
        end
    end

    assign in_rdy  = rdy_c;
    assign out_vld = out_vld_q;
    assign busy    = (cnt != '0);

    for (genvar i = 0; i < NO_CH; i++) begin : g_lane
        popacc_lane #(
            .BW_IN  (BW_IN),
            .BW_OUT (BW_OUT),
            .ACC_W  (ACC_W),
            .SH_W   (SH_W),
            .LS_W   (LS_W)
        ) u_lane (
            .clk    (clk),
            .rst_n  (rst_n),
            .din    (data_in[i]),
            .acc_en (accept),
            .first  (first),
            .shift  (eff_shift),
            .ls     (ls),
            .load   (load),
            .dout   (data_out[i]),
            .ovf    (ovf[i])
        );
    end

endmodule

// File: doc/popcount_shift_accumulator.md
# popcount_shift_accumulator

Multi-channel, runtime-configurable shift-and-accumulate stage for binarised-network popcount results. Each frame takes `cfg_len` beats of signed per-channel popcounts. Each new beat is weighted ×2^cfg_shift relative to the decayed running sum. The scaled integer result goes to a registered, back-pressurable output. It sits between the popcount tree and the batch-norm/threshold stage, and replaces the fixed-length, fixed-shift accumulator with a valid/ready-capable one.

## Interface
- `NO_CH`, 64, channel count
- `BW_IN`, 12, signed input width per channel
- `BW_OUT`, 16, signed output width per channel
- `MAX_CYC`, 8, maximum beats per frame (≥2)
- `MAX_SHIFT`, 2, maximum per-beat shift
- `clk` in 1: clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `clr` in 1: synchronous abort of the partial frame.
- `cfg_len` in `$clog2(MAX_CYC+1)`: beats per frame. 0 is treated as 1; values above `MAX_CYC` are clamped to `MAX_CYC`.
- `cfg_shift` in `$clog2(MAX_SHIFT+1)`: per-beat right shift. Values above `MAX_SHIFT` are clamped.
- `in_vld` in 1 / `in_rdy` out 1: input handshake.
- `data_in` in `[NO_CH][BW_IN]`: signed popcounts.
- `out_vld` out 1 / `out_rdy` in 1: output handshake.
- `data_out` out `[NO_CH][BW_OUT]`: signed results.
- `ovf` out `[NO_CH]`: per-channel saturation flag, valid with `out_vld`.
- `busy` out 1: a frame is partially accumulated.

## Operation
- **Frame config:** `cfg_len` and `cfg_shift` are sampled and latched on the first accepted beat of a frame. Config changes mid-frame are ignored.
- **Accumulator:** width `ACC_W = BW_IN + MAX_SHIFT*(MAX_CYC-1) + $clog2(MAX_CYC) + 1`, so no overflow is possible. Per-frame left shift is `LS = shift*(len-1)`.
- **Beat 0:** `acc = sext(d) << LS`.
- **Beat k:** `acc = (acc >>> shift) + (sext(d) << LS)`. The shift is arithmetic and drops bits (floor).
- **Result:** `r = acc_final >>> LS` (floor), computed per channel from the combinational final-beat sum.
- **Beat counter:**
  - Increments on each accepted beat.
  - The final beat is the one with `cnt == len-1`. It loads the output register and returns the counter to 0.
  - With `len == 1`, every beat is final.
- **Output register:**
  - Loads on an accepted final beat.
  - `out_vld` stays high with the data held stable until `out_rdy`.
  - A load and a drain in the same cycle are allowed.
- **`in_rdy`:** `!clr && !(final_pending && out_vld && !out_rdy)`. Non-final beats are never stalled.
- **`clr`:**
  - Zeroes the counter; the partial sum is discarded.
  - The output register is untouched.
  - `clr` wins over a simultaneous `in_vld`, and that beat is not accepted.
- **`busy`:** `cnt != 0`.

## Timing
- **Reset values:** `out_vld=0`, `data_out=0`, `ovf=0`, `busy=0`, counter 0. `in_rdy=1` once `rst_n` is high.
- **Reset mid-frame:** the partial frame and any pending output are lost.
- **Latency:** `out_vld` rises one cycle after the final beat is accepted.
- **Throughput:** one beat per clock while `out_rdy` is held high, with no bubbles, including `len=1`.
- **Back-pressure:** the final beat of the next frame stalls (`in_rdy=0`) until the held result drains. That beat is accepted in the same cycle `out_rdy` is high.
- **Datapath:** accumulator update is a single cycle. No multi-cycle paths.

## Configuration
- **`POPACC_SAT_EN` defined:** `r` is saturated to `[-2^(BW_OUT-1), 2^(BW_OUT-1)-1]`, and `ovf[i]` is set when channel i clipped.
- **`POPACC_SAT_EN` undefined:** `r` is truncated to its low `BW_OUT` bits (two's-complement wrap), and `ovf` is tied to 0.

## Structure
- **Package `popacc_pkg`:**
  - `ACC_W` computation function
  - `clamp_len` / `clamp_shift` functions
  - `sat_trunc` conversion function, selected by the macro
- **Sub-module `popacc_lane`:** per-channel datapath (accumulator register, shift/add, result conversion, `ovf`). Instantiated `NO_CH` times.
- **Top:** control only (counter, latched config, handshake, output valid).

## Test plan
Bench parameters unless noted: `NO_CH=4`, `BW_IN=12`, `BW_OUT=16`, `MAX_CYC=8`, `MAX_SHIFT=2`.
- `shift=0`, `len=4`, ch0 inputs 1,2,3,4 with `out_rdy=1` -> `data_out[0]=10`, `out_vld` high exactly one cycle after beat 4, `busy` high for beats 2–4.
- `shift=1`, `len=4`, inputs 8,8,8,8 -> result 15. `shift=1`, `len=2`, inputs -3,0 -> result -2 (floor).
- `len=2`, `out_rdy=0`, two frames back to back -> frame 2's beat 1 is accepted, its final beat sees `in_rdy=0` until `out_rdy` rises, and the first result holds stable throughout.
- `BW_OUT=12`, `len=4`, `shift=0`, inputs 2047×4:
  - with `POPACC_SAT_EN`: `data_out=2047`, `ovf=1`
  - without it: `data_out=-4`, `ovf=0`
- `clr` asserted with `in_vld` after 2 of 4 beats -> beat dropped, `busy=0`; the next 4 beats produce the sum of only those 4.
- `rst_n` pulsed low mid-frame (async, between clock edges) -> all outputs go to reset values immediately. The next frame's result is correct and latches `cfg_len`/`cfg_shift` fresh, and a config change mid-frame has no effect.
